// File: rtl/upsample_nearest_mult_if.sv
// -----------------------------------------------------------------------------
// upsample_nearest_mult_if
// Row-vector handshake bundle for the 2x nearest-neighbour upsampler.
//
//   valid_i / ready_o / multi_input_data   : upstream half-width row channel
//   valid_o / ready_i / multi_output_data  : downstream full-width row channel
//   frame_done_o                           : last-row-of-frame strobe
//
// modport slave  : the upsampler side
// modport master : the environment driving rows in and taking rows out
// -----------------------------------------------------------------------------
interface upsample_nearest_mult_if #(
    parameter int DATA_BITS = 8,
    parameter int D         = 1,
    parameter int W         = 24
);
    localparam int IN_W  = (W / 2) * D * DATA_BITS;
    localparam int OUT_W = W * D * DATA_BITS;

    logic             valid_i;
    logic             ready_o;
    logic [IN_W-1:0]  multi_input_data;
    logic             valid_o;
    logic             ready_i;
    logic [OUT_W-1:0] multi_output_data;
    logic             frame_done_o;

    modport slave (
        input  valid_i,
        input  multi_input_data,
        input  ready_i,
        output ready_o,
        output valid_o,
        output multi_output_data,
        output frame_done_o
    );

    modport master (
        output valid_i,
        output multi_input_data,
        output ready_i,
        input  ready_o,
        input  valid_o,
        input  multi_output_data,
        input  frame_done_o
    );
endinterface

// File: rtl/upsample_nearest_mult.sv
// -----------------------------------------------------------------------------
// upsample_nearest_mult
// 2x nearest-neighbour upsampler for row-vector feature maps. Each accepted
// half-width row is expanded horizontally (every pixel duplicated) and emitted
// twice (row A then row B), giving the vertical duplication.
//
// Ports:
//   clk    : clock, all state updates on the rising edge
//   reset  : synchronous active-high reset; aborts any in-flight row pair
//   bus    : upsample_nearest_mult_if.slave
//            valid_i/ready_o/multi_input_data   - half-width input row
//            valid_o/ready_i/multi_output_data  - full-width output row
//            frame_done_o - high during the handshake of output row H-1
//
// Packing (input and output): pixel p, channel d lives at
//   [(p*D+d)*DATA_BITS +: DATA_BITS]
// -----------------------------------------------------------------------------
module upsample_nearest_mult #(
    parameter int DATA_BITS = 8,
    parameter int D         = 1,
    parameter int H         = 24,
    parameter int W         = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    upsample_nearest_mult_if.slave  bus
);
    localparam int IN_W  = (W / 2) * D * DATA_BITS;
    localparam int ROW_W = (H > 2) ? $clog2(H) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(H - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROW_A = 2'd1,
        ROW_B = 2'd2
    } state_t;

    state_t            state_q,   state_d;
    logic [IN_W-1:0]   row_buf_q, row_buf_d;
    logic [ROW_W-1:0]  out_row_q, out_row_d;

    logic              ready_int;
    logic              valid_int;
    logic              out_xfer;
    logic              last_row;

    // -------------------------------------------------------------------------
    // Next-state / output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        row_buf_d = row_buf_q;
        ready_int = 1'b0;
        valid_int = 1'b0;

        case (state_q)
            IDLE: begin
                ready_int = 1'b1;
                if (bus.valid_i) begin
                    row_buf_d = bus.multi_input_data;
                    state_d   = ROW_A;
                end
            end
            ROW_A: begin
                valid_int = 1'b1;
                if (bus.ready_i) begin
                    state_d = ROW_B;
                end
            end
            ROW_B: begin
                valid_int = 1'b1;
                // The buffer is free exactly when row B leaves, so a new row
                // can be captured on that same edge with no bubble.
                ready_int = bus.ready_i;
                if (bus.ready_i) begin
                    if (bus.valid_i) begin
                        row_buf_d = bus.multi_input_data;
                        state_d   = ROW_A;
                    end else begin
                        state_d   = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_xfer = valid_int & bus.ready_i;
    assign last_row = (out_row_q == LAST_ROW);

    always_comb begin
        out_row_d = out_row_q;
        if (out_xfer) begin
            out_row_d = last_row ? '0 : out_row_q + ROW_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            row_buf_q <= '0;
            out_row_q <= '0;
        end else begin
            state_q   <= state_d;
            row_buf_q <= row_buf_d;
            out_row_q <= out_row_d;
        end
    end

    // Upstream must not see ready while reset is held, even though the FSM
    // already sits in IDLE during a multi-cycle reset.
    assign bus.ready_o      = ready_int & ~reset;
    assign bus.valid_o      = valid_int;
    assign bus.frame_done_o = out_xfer & last_row;

    // -------------------------------------------------------------------------
    // Horizontal expansion: output pixel gi takes input pixel gi/2.
    // -------------------------------------------------------------------------
    genvar gi, gj;
    generate
        for (gi = 0; gi < W; gi++) begin : g_pix
            for (gj = 0; gj < D; gj++) begin : g_ch
                assign bus.multi_output_data[(gi*D+gj)*DATA_BITS +: DATA_BITS] =
                    row_buf_q[((gi/2)*D+gj)*DATA_BITS +: DATA_BITS];
            end
        end
    endgenerate
endmodule

// File: tb/tb_upsample_nearest_mult.sv
// -----------------------------------------------------------------------------
// tb_upsample_nearest_mult
// Bench for the 2x nearest-neighbour upsampler, configured with D=2, W=8, H=4
// so multi-channel packing and frame wrap are both exercised.
// The reference model is a queue of expected output rows: every accepted input
// row is expanded by the pixel rule and queued twice. Output valid, input ready
// and frame_done are derived from the queue occupancy and a transfer count.
// -----------------------------------------------------------------------------
module tb_upsample_nearest_mult;
    localparam int DB    = 8;
    localparam int D     = 2;
    localparam int W     = 8;
    localparam int H     = 4;
    localparam int IN_W  = (W / 2) * D * DB;
    localparam int OUT_W = W * D * DB;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    upsample_nearest_mult_if #(.DATA_BITS(DB), .D(D), .W(W)) bus ();

    upsample_nearest_mult #(
        .DATA_BITS(DB), .D(D), .H(H), .W(W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int               checks = 0;
    int               errors = 0;
    logic [OUT_W-1:0] exp_q[$];
    int               xfer_cnt = 0;
    bit               rst_at_edge = 1'b0;
    bit               last_acc = 1'b0;

    // Output pixel x, channel d copies input pixel x/2, channel d.
    function automatic logic [OUT_W-1:0] expand(input logic [IN_W-1:0] r);
        logic [OUT_W-1:0] o;
        o = '0;
        for (int x = 0; x < W; x++)
            for (int d = 0; d < D; d++)
                o[(x*D+d)*DB +: DB] = r[((x/2)*D+d)*DB +: DB];
        return o;
    endfunction

    task automatic chk(input string tag, input logic [OUT_W-1:0] got,
                       input logic [OUT_W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Evaluated at the falling edge: compares DUT outputs with the model and
    // advances the model by the handshakes that will happen at the next edge.
    task automatic monitor();
        bit exp_valid, exp_ready, out_x, in_x, exp_fd;
        logic [OUT_W-1:0] row;
        if (reset) begin
            chk("ready_o_in_reset", bus.ready_o, 0);
            if (rst_at_edge) begin
                chk("valid_o_in_reset", bus.valid_o, 0);
                chk("data_in_reset", bus.multi_output_data, 0);
                chk("frame_done_in_reset", bus.frame_done_o, 0);
            end
            exp_q.delete();
            xfer_cnt = 0;
            last_acc = 1'b0;
            return;
        end
        exp_valid = (exp_q.size() > 0);
        exp_ready = (exp_q.size() == 0) ? 1'b1 :
                    (exp_q.size() == 1) ? bus.ready_i : 1'b0;
        chk("valid_o", bus.valid_o, exp_valid);
        chk("ready_o", bus.ready_o, exp_ready);
        if (rst_at_edge) chk("data_after_reset", bus.multi_output_data, 0);
        if (exp_valid) chk("data", bus.multi_output_data, exp_q[0]);
        out_x  = exp_valid && bus.ready_i;
        exp_fd = out_x && ((xfer_cnt % H) == H - 1);
        chk("frame_done", bus.frame_done_o, exp_fd);
        in_x = bus.valid_i && exp_ready;
        if (out_x) begin
            void'(exp_q.pop_front());
            xfer_cnt++;
        end
        if (in_x) begin
            row = expand(bus.multi_input_data);
            exp_q.push_back(row);
            exp_q.push_back(row);
        end
        last_acc = in_x;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        rst_at_edge = reset;
        #1;
    endtask

    function automatic logic [IN_W-1:0] rnd_row();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic [IN_W-1:0]  const_in;
        logic [OUT_W-1:0] const_out;
        int n, cyc;

        reset = 1'b1;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        bus.multi_input_data = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Directed multi-channel row: p0=(11,22) p1=(AA,BB) p2=(CC,DD) p3=(66,77)
        const_in  = 64'h7766_DDCC_BBAA_2211;
        const_out = 128'h7766_7766_DDCC_DDCC_BBAA_BBAA_2211_2211;
        bus.ready_i = 1'b1;
        bus.valid_i = 1'b1;
        bus.multi_input_data = const_in;
        tick();
        bus.valid_i = 1'b0;
        chk("const_rowA_valid", bus.valid_o, 1);
        chk("const_rowA_data", bus.multi_output_data, const_out);
        tick();
        chk("const_rowB_data", bus.multi_output_data, const_out);
        repeat (3) tick();
        chk("idle_ready", bus.ready_o, 1);

        // Back-to-back rows with ready_i held high
        bus.valid_i = 1'b1;
        bus.multi_input_data = rnd_row();
        n = 0; cyc = 0;
        while (n < 12 && cyc < 100) begin
            tick();
            cyc++;
            if (last_acc) begin
                n++;
                bus.multi_input_data = rnd_row();
            end
        end
        chk("b2b_rows_accepted", n, 12);
        bus.valid_i = 1'b0;
        repeat (4) tick();

        // Backpressure in ROW_A, then in ROW_B, with a second row offered
        bus.valid_i = 1'b1;
        bus.ready_i = 1'b0;
        bus.multi_input_data = rnd_row();
        tick();
        bus.multi_input_data = rnd_row();
        repeat (5) tick();
        bus.ready_i = 1'b1;
        tick();
        bus.ready_i = 1'b0;
        repeat (5) tick();
        bus.ready_i = 1'b1;
        tick();
        bus.valid_i = 1'b0;
        repeat (4) tick();

        // Random valid/ready mix
        for (int i = 0; i < 300; i++) begin
            if (!bus.valid_i || last_acc) begin
                bus.valid_i = 1'($urandom_range(0, 1));
                bus.multi_input_data = rnd_row();
            end
            bus.ready_i = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        repeat (4) tick();

        // Reset while holding row B
        bus.valid_i = 1'b1;
        bus.multi_input_data = rnd_row();
        tick();
        bus.valid_i = 1'b0;
        tick();
        bus.ready_i = 1'b0;
        tick();
        chk("rowB_held_valid", bus.valid_o, 1);
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        bus.ready_i = 1'b1;
        tick();

        // Fresh frame after reset: frame_done lands after H more transfers
        bus.valid_i = 1'b1;
        bus.multi_input_data = rnd_row();
        n = 0; cyc = 0;
        while (n < 3 && cyc < 50) begin
            tick();
            cyc++;
            if (last_acc) begin
                n++;
                bus.multi_input_data = rnd_row();
            end
        end
        chk("post_reset_rows_accepted", n, 3);
        bus.valid_i = 1'b0;
        repeat (4) tick();
        chk("model_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
